// File: rtl/axi_sram_rd_arbiter_pkg.sv
// Shared widths, R payload field offsets and FSM encoding for the SRAM read arbiter.
// AR payload {araddr[31:0], arid[3:0], arlen[7:0], arsize[2:0], arburst[1:0], arlock, arcache[3:0], arprot[2:0]}.
package axi_sram_rd_arbiter_pkg;
  localparam int AR_PAYLOAD_W = 57;
  localparam int R_PAYLOAD_W  = 39;   // {rdata[31:0], rid[3:0], rresp[1:0], rlast}
  localparam int R_RLAST_BIT  = 0;
  localparam int R_RDATA_LSB  = 7;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;
endpackage

// File: rtl/axi_rd_grant_sel.sv
// One-hot read grant between fetch (bit 0) and LSU (bit 1).
// ARB_ROUND_ROBIN_EN: ties go to the requester that did not win last; otherwise LSU always wins ties.
module axi_rd_grant_sel (
  input  logic       i_v0,
  input  logic       i_v1,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt
);
  logic w_tie_s1;

`ifdef ARB_ROUND_ROBIN_EN
  assign w_tie_s1 = ~i_last_grant;
`else
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
  assign w_tie_s1            = 1'b1;
`endif

  assign o_gnt[1] = i_v1 & (~i_v0 | w_tie_s1);
  assign o_gnt[0] = i_v0 & ~o_gnt[1];
endmodule

// File: rtl/axi_sram_rd_arbiter.sv
// 2:1 AXI read arbiter in front of the single-port SRAM bridge; one read outstanding at a time.
// Tie-break selected by ARB_ROUND_ROBIN_EN (see axi_rd_grant_sel).
module axi_sram_rd_arbiter
  import axi_sram_rd_arbiter_pkg::*;
#(
  parameter int AR_PW = AR_PAYLOAD_W,
  parameter int R_PW  = R_PAYLOAD_W
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s0_arvalid,
  output logic             s0_arready,
  input  logic [AR_PW-1:0] s0_ar,
  output logic             s0_rvalid,
  input  logic             s0_rready,
  output logic [R_PW-1:0]  s0_r,
  input  logic             s1_arvalid,
  output logic             s1_arready,
  input  logic [AR_PW-1:0] s1_ar,
  output logic             s1_rvalid,
  input  logic             s1_rready,
  output logic [R_PW-1:0]  s1_r,
  output logic             m_arvalid,
  input  logic             m_arready,
  output logic [AR_PW-1:0] m_ar,
  input  logic             m_rvalid,
  output logic             m_rready,
  input  logic [R_PW-1:0]  m_r,
  input  logic             wr_inflight
);
  arb_state_e       r_state, w_next;
  logic             r_owner;
  logic             r_last_grant;
  logic [AR_PW-1:0] r_m_ar;
  logic [1:0]       w_gnt;
  logic             w_grant;

  axi_rd_grant_sel u_sel (
    .i_v0         (s0_arvalid),
    .i_v1         (s1_arvalid),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_gnt)
  );

  // A grant is the AR handshake itself: the winner is always valid.
  assign w_grant = (r_state == ARB_IDLE) & ~wr_inflight & (s0_arvalid | s1_arvalid);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ARB_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_m_ar       <= '0;
    end else if (w_grant) begin
      r_owner      <= w_gnt[1];
      r_last_grant <= w_gnt[1];
      r_m_ar       <= w_gnt[1] ? s1_ar : s0_ar;
    end
  end

  always_comb begin
    w_next     = r_state;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        s0_arready = ~wr_inflight & w_gnt[0];
        s1_arready = ~wr_inflight & w_gnt[1];
        if (w_grant) w_next = ARB_ADDR;
      end
      ARB_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) w_next = ARB_DATA;
      end
      ARB_DATA: begin
        m_rready  = r_owner ? s1_rready : s0_rready;
        s0_rvalid = ~r_owner & m_rvalid;
        s1_rvalid = r_owner & m_rvalid;
        if (m_rvalid & m_rready & m_r[R_RLAST_BIT]) w_next = ARB_IDLE;
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  assign m_ar = r_m_ar;
  assign s0_r = m_r;
  assign s1_r = m_r;
endmodule
